// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter in front of the single regfile write port.
//   Merges the in-order main pipe with results from a long-latency unit
//   (mul/div). Long results wait in a small FIFO. The pipe has priority
//   until the queue has lost STARVE_MAX grants in a row. A busy scoreboard
//   tracks registers that still have a long result outstanding.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pipe_valid/ready/we/addr/data   main-pipe result handshake
//   long_valid/ready/addr/data      long-unit result handshake (ready = !full)
//   rsv_en/rsv_addr            issue-time reservation of a long-op destination
//   busy_vec                   1 = long result pending for that register
//   rw_en/rw_addr/rw_data      registered regfile write port
// Optional feature: define WB_BYPASS_EN to add fwd_en/fwd_addr/fwd_data.
//   These outputs show combinationally the values rw_* will take next cycle.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int REG_NUM    = 32,
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_valid,
  output logic               pipe_ready,
  input  logic               pipe_we,
  input  logic [REG_W-1:0]   pipe_addr,
  input  logic [DATA_W-1:0]  pipe_data,
  input  logic               long_valid,
  output logic               long_ready,
  input  logic [REG_W-1:0]   long_addr,
  input  logic [DATA_W-1:0]  long_data,
  input  logic               rsv_en,
  input  logic [REG_W-1:0]   rsv_addr,
  output logic [REG_NUM-1:0] busy_vec,
  output logic               rw_en,
  output logic [REG_W-1:0]   rw_addr,
  output logic [DATA_W-1:0]  rw_data
`ifdef WB_BYPASS_EN
  ,
  output logic               fwd_en,
  output logic [REG_W-1:0]   fwd_addr,
  output logic [DATA_W-1:0]  fwd_data
`endif
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic [REG_W-1:0]   lq_addr_q [LQ_DEPTH];
  logic [REG_W-1:0]   lq_addr_d [LQ_DEPTH];
  logic [DATA_W-1:0]  lq_data_q [LQ_DEPTH];
  logic [DATA_W-1:0]  lq_data_d [LQ_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ST_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               rw_en_q, rw_en_d;
  logic [REG_W-1:0]   rw_addr_q, rw_addr_d;
  logic [DATA_W-1:0]  rw_data_q, rw_data_d;

  logic               full, empty, push, pop, lq_win;
  logic [REG_W-1:0]   head_addr;
  logic [DATA_W-1:0]  head_data;

  // Grant decision. Only the registered head is visible here, so a result
  // pushed this cycle cannot be granted before the next one.
  always_comb begin
    full       = (count_q == CNT_W'(LQ_DEPTH));
    empty      = (count_q == '0);
    long_ready = !full;
    push       = long_valid && !full;
    lq_win     = !empty && (!pipe_valid || starve_cnt_q == ST_W'(STARVE_MAX));
    pop        = lq_win;
    pipe_ready = !lq_win;
    head_addr  = lq_addr_q[rd_ptr_q];
    head_data  = lq_data_q[rd_ptr_q];
  end

  // Long-result FIFO
  always_comb begin
    lq_addr_d = lq_addr_q;
    lq_data_d = lq_data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      lq_addr_d[wr_ptr_q] = long_addr;
      lq_data_d[wr_ptr_q] = long_data;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The starvation count advances only when the pipe beats a non-empty queue.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop || empty) begin
      starve_cnt_d = '0;
    end else if (pipe_valid && starve_cnt_q != ST_W'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Write port. With no grant the address and data hold.
  always_comb begin
    rw_en_d   = 1'b0;
    rw_addr_d = rw_addr_q;
    rw_data_d = rw_data_q;
    if (lq_win) begin
      rw_en_d   = (head_addr != '0);
      rw_addr_d = head_addr;
      rw_data_d = head_data;
    end else if (pipe_valid) begin
      rw_en_d   = pipe_we && (pipe_addr != '0);
      rw_addr_d = pipe_addr;
      rw_data_d = pipe_data;
    end
  end

  // Scoreboard. The set is applied after the clear, so the set wins when
  // both hit the same register.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_addr] = 1'b0;
    end
    if (rsv_en && rsv_addr != '0) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lq_addr_q    <= '{default: '0};
      lq_data_q    <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      busy_q       <= '0;
      rw_en_q      <= 1'b0;
      rw_addr_q    <= '0;
      rw_data_q    <= '0;
    end else begin
      lq_addr_q    <= lq_addr_d;
      lq_data_q    <= lq_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
      rw_en_q      <= rw_en_d;
      rw_addr_q    <= rw_addr_d;
      rw_data_q    <= rw_data_d;
    end
  end

  assign busy_vec = busy_q;
  assign rw_en    = rw_en_q;
  assign rw_addr  = rw_addr_q;
  assign rw_data  = rw_data_q;

`ifdef WB_BYPASS_EN
  assign fwd_en   = rw_en_d;
  assign fwd_addr = rw_addr_d;
  assign fwd_data = rw_data_d;
`endif

endmodule
